// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the text-VRAM port arbiter.
// Imported by vram_port_arbiter.
package vram_arb_pkg;

  localparam int ADDR_W_DFLT = 10;
  localparam int DATA_W_DFLT = 32;
  localparam int STRB_W_DFLT = 4;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_PEND = 2'd1,
    H_RD1  = 2'd2,
    H_RD2  = 2'd3
  } host_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == CONFLICT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_port_arbiter.sv
// Single-port text VRAM arbiter: display glyph fetch has absolute priority,
// the host gets any free cycle and is monitored for starvation.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DFLT,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int STRB_W       = STRB_W_DFLT,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              pixel_clk,
  input  logic              arstn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [STRB_W-1:0] host_strb,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_wdone,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starve,
  output logic [15:0]       conflict_cnt,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  host_state_t       state_q, state_d;
  logic              hreq_we_q, hreq_we_d;
  logic [STRB_W-1:0] hreq_strb_q, hreq_strb_d;
  logic [ADDR_W-1:0] hreq_addr_q, hreq_addr_d;
  logic [DATA_W-1:0] hreq_wdata_q, hreq_wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       conflict_q, conflict_d;
  logic              starve_q, starve_d;
  logic              wdone_q, wdone_d;
  logic              hrvalid_q, hrvalid_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              ready_q, ready_d;
  logic              dpipe_q, dpipe_d;
  logic              drvalid_q, drvalid_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic disp_fire;
  logic host_grant;

  // Grant decode; nothing reaches the BRAM while reset is held.
  always_comb begin
    disp_fire  = disp_req & arstn;
    host_grant = arstn & (state_q == H_PEND) & ~disp_req;
  end

  // BRAM port mux driven from this cycle's grant.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = {STRB_W{1'b0}};
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    if (disp_fire) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (host_grant) begin
      ram_en   = 1'b1;
      ram_addr = hreq_addr_q;
      if (hreq_we_q) begin
        ram_we    = hreq_strb_q;
        ram_wdata = hreq_wdata_q;
      end else begin
        ram_we    = {STRB_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
      end
    end else begin
      ram_en = 1'b0;
    end
  end

  // Host FSM next-state, request latch, wait/conflict bookkeeping.
  always_comb begin
    state_d      = state_q;
    hreq_we_d    = hreq_we_q;
    hreq_strb_d  = hreq_strb_q;
    hreq_addr_d  = hreq_addr_q;
    hreq_wdata_d = hreq_wdata_q;
    wait_d       = wait_q;
    conflict_d   = conflict_q;
    starve_d     = 1'b0;
    wdone_d      = 1'b0;
    hrvalid_d    = 1'b0;
    hrdata_d     = hrdata_q;
    case (state_q)
      H_IDLE: begin
        if (host_valid) begin
          hreq_we_d    = host_we;
          hreq_strb_d  = host_strb;
          hreq_addr_d  = host_addr;
          hreq_wdata_d = host_wdata;
          wait_d       = {WAIT_W{1'b0}};
          state_d      = H_PEND;
        end else begin
          state_d = H_IDLE;
        end
      end
      H_PEND: begin
        if (disp_req) begin
          if (wait_q == WAIT_MAX) begin
            wait_d = wait_q;
          end else begin
            wait_d = wait_q + WAIT_ONE;
          end
          starve_d   = (wait_q == WAIT_PRE);
          conflict_d = sat_inc16(conflict_q);
        end else if (hreq_we_q) begin
          wdone_d = 1'b1;
          state_d = H_IDLE;
        end else begin
          state_d = H_RD1;
        end
      end
      H_RD1: begin
        // Data from the grant cycle arrives here, even if display uses the port now.
        hrdata_d  = ram_rdata;
        hrvalid_d = 1'b1;
        state_d   = H_RD2;
      end
      H_RD2: begin
        state_d = H_IDLE;
      end
      default: begin
        state_d = H_IDLE;
      end
    endcase
    ready_d = (state_d == H_IDLE);
  end

  // Display read pipeline: fixed two-cycle return, never stalled.
  always_comb begin
    dpipe_d   = disp_fire;
    drvalid_d = dpipe_q;
    if (dpipe_q) begin
      drdata_d = ram_rdata;
    end else begin
      drdata_d = drdata_q;
    end
  end

  // Host-side state and registered host outputs.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_q      <= H_IDLE;
      hreq_we_q    <= 1'b0;
      hreq_strb_q  <= {STRB_W{1'b0}};
      hreq_addr_q  <= {ADDR_W{1'b0}};
      hreq_wdata_q <= {DATA_W{1'b0}};
      wait_q       <= {WAIT_W{1'b0}};
      conflict_q   <= 16'd0;
      starve_q     <= 1'b0;
      wdone_q      <= 1'b0;
      hrvalid_q    <= 1'b0;
      hrdata_q     <= {DATA_W{1'b0}};
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hreq_we_q    <= hreq_we_d;
      hreq_strb_q  <= hreq_strb_d;
      hreq_addr_q  <= hreq_addr_d;
      hreq_wdata_q <= hreq_wdata_d;
      wait_q       <= wait_d;
      conflict_q   <= conflict_d;
      starve_q     <= starve_d;
      wdone_q      <= wdone_d;
      hrvalid_q    <= hrvalid_d;
      hrdata_q     <= hrdata_d;
      ready_q      <= ready_d;
    end
  end

  // Display pipeline registers; reset drops any read in flight.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      dpipe_q   <= 1'b0;
      drvalid_q <= 1'b0;
      drdata_q  <= {DATA_W{1'b0}};
    end else begin
      dpipe_q   <= dpipe_d;
      drvalid_q <= drvalid_d;
      drdata_q  <= drdata_d;
    end
  end

  assign disp_rvalid  = drvalid_q;
  assign disp_rdata   = drdata_q;
  assign host_ready   = ready_q;
  assign host_wdone   = wdone_q;
  assign host_rvalid  = hrvalid_q;
  assign host_rdata   = hrdata_q;
  assign host_starve  = starve_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a behavioural byte-enable BRAM.
module tb_vram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          pixel_clk = 1'b0;
  logic          arstn;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [SW-1:0] host_strb;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_wdone;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          host_starve;
  logic [15:0]   conflict_cnt;
  logic          ram_en;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vram_port_arbiter dut (
    .pixel_clk(pixel_clk), .arstn(arstn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_strb(host_strb), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_wdone(host_wdone), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_starve(host_starve), .conflict_cnt(conflict_cnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // BRAM model: unwritten words read back as pat(addr).
  logic [DW-1:0] mem [0:1023];
  bit            wr_seen [0:1023];
  always @(posedge pixel_clk) begin
    if (ram_en) begin
      ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : pat(ram_addr);
      for (int b = 0; b < SW; b++) begin
        if (ram_we[b]) begin
          if (!wr_seen[ram_addr]) mem[ram_addr] = pat(ram_addr);
          mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
          wr_seen[ram_addr] = 1'b1;
        end
      end
    end
  end

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t dq[$];
  exp_t rq[$];
  int   wq[$];
  int   sq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge pixel_clk) begin
    exp_t e;
    int   d;
    if (disp_rvalid === 1'b1) begin
      if (dq.size() == 0) chk("disp_rvalid_unexpected", {31'd0, disp_rvalid}, 32'd0);
      else begin
        e = dq.pop_front();
        chk("disp_rdata", disp_rdata, e.data);
        chk("disp_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (host_rvalid === 1'b1) begin
      if (rq.size() == 0) chk("host_rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
      else begin
        e = rq.pop_front();
        chk("host_rdata", host_rdata, e.data);
        if (e.due != 0) chk("host_rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (host_wdone === 1'b1) begin
      if (wq.size() == 0) chk("host_wdone_unexpected", {31'd0, host_wdone}, 32'd0);
      else begin
        d = wq.pop_front();
        if (d != 0) chk("host_wdone_cycle", 32'(cyc), 32'(d));
      end
    end
    if (host_starve === 1'b1) begin
      if (sq.size() == 0) chk("host_starve_unexpected", {31'd0, host_starve}, 32'd0);
      else begin
        d = sq.pop_front();
        chk("host_starve_cycle", 32'(cyc), 32'(d));
      end
    end
  end

  task automatic step();
    @(posedge pixel_clk); #1;
    disp_req = 1'b0;
    host_valid = 1'b0;
  endtask

  task automatic step_h();
    @(posedge pixel_clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic step_d();
    @(posedge pixel_clk); #1;
    disp_req = 1'b0;
  endtask

  task automatic host_wait_idle();
    int n = 0;
    while (host_ready !== 1'b1 && n < 64) begin
      step_h();
      n++;
    end
    if (host_ready !== 1'b1) chk("host_ready_timeout", {31'd0, host_ready}, 32'd1);
  endtask

  task automatic host_drive(input logic we, input logic [3:0] s, input logic [AW-1:0] a,
                            input logic [31:0] d);
    host_we = we; host_strb = s; host_addr = a; host_wdata = d; host_valid = 1'b1;
  endtask

  task automatic disp_issue(input logic [AW-1:0] a, input logic [31:0] d, input bit push);
    exp_t e;
    disp_req = 1'b1;
    disp_addr = a;
    if (push) begin
      e.data = d;
      e.due = cyc + 2;
      dq.push_back(e);
    end
  endtask

  task automatic push_rd(input logic [31:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due = due;
    rq.push_back(e);
  endtask

  task automatic chk_ram(input string name, input logic [3:0] we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input bit chk_wd);
    #2;
    chk({name, "_en"}, {31'd0, ram_en}, 32'd1);
    chk({name, "_we"}, {28'd0, ram_we}, {28'd0, we});
    chk({name, "_addr"}, {22'd0, ram_addr}, {22'd0, a});
    if (chk_wd) chk({name, "_wdata"}, ram_wdata, wd);
  endtask

  logic [31:0] shadow [0:63];
  bit          disp_done;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    arstn = 1'b0; disp_req = 1'b0; disp_addr = '0; host_valid = 1'b0; host_we = 1'b0;
    host_strb = '0; host_addr = '0; host_wdata = '0; disp_done = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = pat(AW'(10'h100 + i));

    // Reset state
    repeat (3) step();
    chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
    chk("rst_outputs", {28'd0, disp_rvalid, host_rvalid, host_wdone, host_starve}, 32'd0);
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    arstn = 1'b1;
    chk("rel_ready_same_cycle", {31'd0, host_ready}, 32'd0);
    step();
    chk("rel_ready_next_cycle", {31'd0, host_ready}, 32'd1);

    // Earliest write then read latency, no display traffic
    host_wait_idle();
    a = cyc;
    host_drive(1'b1, 4'hF, 10'h002, 32'h00FF0000);
    wq.push_back(a + 2);
    step();
    chk("t1_ready_pend", {31'd0, host_ready}, 32'd0);
    chk_ram("t1_wr_grant", 4'hF, 10'h002, 32'h00FF0000, 1'b1);
    step();
    host_wait_idle();
    a = cyc;
    host_drive(1'b0, 4'h0, 10'h002, 32'h0);
    push_rd(32'h00FF0000, a + 3);
    step();
    chk_ram("t1_rd_grant", 4'h0, 10'h002, 32'h0, 1'b0);
    repeat (3) step();

    // Display held 20 cycles while a host read waits
    host_wait_idle();
    a = cyc;
    host_drive(1'b0, 4'h0, 10'h004, 32'h0);
    push_rd(32'hC0DE0004, a + 23);
    sq.push_back(a + 17);
    step();
    for (int i = 0; i < 20; i++) begin
      disp_issue(AW'(10'h040 + i), pat(AW'(10'h040 + i)), 1'b1);
      step();
    end
    chk("t2_conflict_cnt", {16'd0, conflict_cnt}, 32'd20);
    chk_ram("t2_grant", 4'h0, 10'h004, 32'h0, 1'b0);
    repeat (3) step();

    // Partial-strobe write, display reads the word the cycle after the grant
    host_wait_idle();
    a = cyc;
    host_drive(1'b1, 4'hF, 10'h00A, 32'h12345678);
    wq.push_back(a + 2);
    step();
    step();
    host_wait_idle();
    a = cyc;
    host_drive(1'b1, 4'h3, 10'h00A, 32'hAAAA5555);
    wq.push_back(a + 2);
    step();
    chk_ram("t3_grant", 4'h3, 10'h00A, 32'hAAAA5555, 1'b1);
    step();
    disp_issue(10'h00A, 32'h12345555, 1'b1);
    repeat (3) step();

    // Display and host request in the same cycle
    host_wait_idle();
    a = cyc;
    disp_issue(10'h050, pat(10'h050), 1'b1);
    host_drive(1'b0, 4'h0, 10'h00A, 32'h0);
    push_rd(32'h12345555, a + 4);
    chk_ram("t4_disp_wins", 4'h0, 10'h050, 32'h0, 1'b0);
    step();
    disp_issue(10'h051, pat(10'h051), 1'b1);
    chk("t4_ready_a1", {31'd0, host_ready}, 32'd0);
    chk_ram("t4_disp_again", 4'h0, 10'h051, 32'h0, 1'b0);
    step();
    chk_ram("t4_host_grant", 4'h0, 10'h00A, 32'h0, 1'b0);
    chk("t4_conflict_cnt", {16'd0, conflict_cnt}, 32'd21);
    step();
    chk("t4_ready_a3", {31'd0, host_ready}, 32'd0);
    step();
    chk("t4_ready_a4", {31'd0, host_ready}, 32'd0);
    step();
    chk("t4_ready_a5", {31'd0, host_ready}, 32'd1);

    // Reset while the host read sits in H_RD1
    host_wait_idle();
    host_drive(1'b0, 4'h0, 10'h00A, 32'h0);
    step();
    step();
    arstn = 1'b0;
    disp_issue(10'h060, 32'h0, 1'b0);
    #2;
    chk("t5_ram_en_in_reset", {31'd0, ram_en}, 32'd0);
    step();
    chk("t5_rst_outputs", {27'd0, host_ready, disp_rvalid, host_rvalid, host_wdone, host_starve}, 32'd0);
    chk("t5_rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    chk("t5_rst_rdata", host_rdata, 32'd0);
    step();
    arstn = 1'b1;
    chk("t5_rel_ready_same", {31'd0, host_ready}, 32'd0);
    step();
    chk("t5_rel_ready_next", {31'd0, host_ready}, 32'd1);

    // Periodic display reads with random host traffic
    fork
      begin
        for (int c = 0; c < 800; c++) begin
          step_d();
          if (c % 8 == 0) begin
            logic [AW-1:0] da;
            da = AW'(10'h080 + $urandom_range(0, 127));
            disp_issue(da, pat(da), 1'b1);
          end
        end
        step_d();
        disp_done = 1'b1;
      end
      begin
        while (!disp_done) begin
          int unsigned idx;
          logic [31:0] wd;
          logic [3:0]  s;
          host_wait_idle();
          idx = $urandom_range(0, 63);
          if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            shadow[idx] = merge(shadow[idx], wd, s);
            wq.push_back(0);
            host_drive(1'b1, s, AW'(10'h100 + idx), wd);
          end else begin
            push_rd(shadow[idx], 0);
            host_drive(1'b0, 4'h0, AW'(10'h100 + idx), 32'h0);
          end
          step_h();
          repeat ($urandom_range(0, 3)) step_h();
        end
      end
    join

    repeat (10) step();
    chk("end_disp_pending", 32'(dq.size()), 32'd0);
    chk("end_host_rd_pending", 32'(rq.size()), 32'd0);
    chk("end_host_wr_pending", 32'(wq.size()), 32'd0);
    chk("end_starve_pending", 32'(sq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single-port text VRAM (BRAM, 1-cycle read latency, byte write enables) between two requesters: the pixel-side glyph fetch (display) and the AXI-side register access (host), with host requests already synchronized into pixel_clk.
- Display always has priority; host gets any free cycle, with a bounded-wait monitor.
- Sits between the AXI slave logic and the VRAM inside the HDMI text controller.

Parameters:
- ADDR_W, 10, VRAM word address width (600 words + control used).
- DATA_W, 32, VRAM word width.
- STRB_W, 4, byte strobes, DATA_W/8.
- STARVE_LIMIT, 16, host wait cycles before host_starve pulses.

Ports:
- pixel_clk  in  1  clock.
- arstn  in  1  reset, synchronous, active-low.
- disp_req  in  1  display read request, single-cycle, may repeat every cycle.
- disp_addr  in  ADDR_W  display word address.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DATA_W  display read data.
- host_valid  in  1  host request valid.
- host_ready  out  1  host slot free.
- host_we  in  1  1=write, 0=read.
- host_strb  in  STRB_W  byte enables, writes only.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_wdone  out  1  write-complete pulse.
- host_rvalid  out  1  read-data-valid pulse.
- host_rdata  out  DATA_W  host read data.
- host_starve  out  1  pulse when host wait reaches STARVE_LIMIT.
- conflict_cnt  out  16  saturating count of host-lost cycles.
- ram_en  out  1  BRAM enable.
- ram_we  out  STRB_W  BRAM byte write enables.
- ram_addr  out  ADDR_W  BRAM address.
- ram_wdata  out  DATA_W  BRAM write data.
- ram_rdata  in  DATA_W  BRAM read data, valid 1 cycle after ram_en.

Behaviour:
- Reset (arstn=0 at posedge):
  - All outputs 0, except host_ready=1 one cycle after release.
  - Host state H_IDLE; pending request, wait counter and conflict_cnt cleared.
  - An in-flight read is dropped: no disp_rvalid, host_rvalid or host_wdone is emitted afterward.
- Port drive is combinational from the current cycle's grant; the BRAM registers on the next edge.
- Display path:
  - disp_req=1 in cycle N → ram_en=1, ram_we=0, ram_addr=disp_addr in N.
  - disp_rvalid=1 and disp_rdata=ram_rdata registered in N+2. Fixed latency 2, no stall, unconditional.
- Host FSM, states H_IDLE, H_PEND, H_RD1, H_RD2:
  - H_IDLE: host_ready=1. On host_valid: latch we/strb/addr/wdata, go to H_PEND, wait counter=0.
  - H_PEND: host_ready=0.
    - If disp_req=1: stay; wait counter +1 (saturate at STARVE_LIMIT); conflict_cnt +1 (saturate 16'hFFFF).
    - host_starve pulses one cycle when the wait counter transitions to STARVE_LIMIT.
    - If disp_req=0: grant. ram_en=1, ram_addr=latched addr.
      - Write: ram_we=latched strb, ram_wdata=latched wdata; host_wdone=1 next cycle; return to H_IDLE.
      - Read: ram_we=0; go to H_RD1.
  - H_RD1 → H_RD2: host_rdata captured from ram_rdata; host_rvalid=1 during H_RD2; then H_IDLE.
- Timing and ordering:
  - Earliest host latency: accept at A, grant at A+1, wdone at A+2, rvalid at A+3.
  - At most one host request outstanding.
  - host_strb=0 write: grant still consumed, ram_we=0, host_wdone still pulses.
- Simultaneous events:
  - disp_req and a host grant in the same cycle: display wins, host stays in H_PEND.
  - Host write granted at G, display read of the same address at G+1: display returns new data.
- Display read cycles may overlap H_RD1/H_RD2. The BRAM is free once the host grant cycle has passed.
- Address width: inputs are used as-is, no range check; out-of-range addresses wrap modulo 2^ADDR_W.

Decomposition:
- Package vram_arb_pkg holds host_state_t (H_IDLE, H_PEND, H_RD1, H_RD2), default ADDR_W/DATA_W/STRB_W constants, and CONFLICT_MAX=16'hFFFF.
- No sub-module. The BRAM is instantiated by the parent.

Test Plan:
- Reset, then host write addr 0x002 data 0x00FF0000 strb 0xF, no display traffic → ram_we=0xF at A+1, host_wdone at A+2. Then host read 0x002 → host_rvalid at A'+3 with 0x00FF0000.
- disp_req held 20 consecutive cycles while host read of 0x004 is pending:
  - host_starve pulses once, at wait=16.
  - conflict_cnt=20.
  - Grant in the first cycle after disp_req drops.
  - All 20 disp_rvalid pulses arrive, each 2 cycles after its request.
- Host write strb 0x3 data 0xAAAA5555 onto word 0x12345678 at addr 0x00A, then display read 0x00A the next cycle → disp_rdata=0x12345555.
- disp_req and host_valid asserted in the same cycle → ram_addr=disp_addr in that cycle; host granted the next free cycle; host_ready low until completion.
- arstn low during H_RD1 → no host_rvalid; all outputs 0; host_ready=1 one cycle after release.
- Display read every 8th cycle across 800 cycles with random host traffic → zero missed or late disp_rvalid; every accepted host request completes.
